// File: rtl/inst_queue_pkg.sv
// Shared definitions for the IF->ID instruction queue: MIPS opcode/function
// constants used by branch pre-decode and the queue state encoding.
package inst_queue_pkg;

    localparam logic [5:0] SPEC   = 6'h00;
    localparam logic [5:0] REGIMM = 6'h01;
    localparam logic [5:0] J      = 6'h02;
    localparam logic [5:0] JAL    = 6'h03;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;
    localparam logic [5:0] BLEZ   = 6'h06;
    localparam logic [5:0] BGTZ   = 6'h07;

    localparam logic [5:0] JR     = 6'h08;
    localparam logic [5:0] JALR   = 6'h09;

    typedef enum logic {
        IQ_RUN     = 1'b0,
        IQ_WAIT_DS = 1'b1
    } iq_state_t;

    // REGIMM branches are BLTZ/BGEZ/BLTZAL/BGEZAL (rt = 0,1,16,17); the
    // remaining REGIMM encodings are traps and must not be flagged.
    function automatic logic regimm_is_branch(input logic [4:0] rt);
        return (rt[3:1] == 3'b000);
    endfunction

endpackage

// File: rtl/inst_queue_branch_predecode.sv
// Combinational branch/jump classifier applied to each fetched word before
// it is written into the queue.
module branch_predecode
    import inst_queue_pkg::*;
(
    input  logic [31:0] inst,
    output logic        is_branch
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    always_comb begin
        is_branch = 1'b0;
        case (opcode)
            SPEC:   is_branch = (funct == JR) || (funct == JALR);
            REGIMM: is_branch = regimm_is_branch(inst[20:16]);
            J, JAL, BEQ, BNE, BLEZ, BGTZ: is_branch = 1'b1;
            default: is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction buffer between fetch and decode with branch
// pre-decode and MIPS delay-slot preservation on redirect.
//
// Handshake: fetch may present in_valid only while in_ready is high; when
// in_ready is low the inputs are ignored and fetch holds them. Decode sees
// out_valid lanes contiguous from lane 0 and acknowledges by returning the
// number of consumed lanes on out_take in the same cycle.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [FETCH_W-1:0]      in_valid,
    input  logic [32*FETCH_W-1:0]   in_pc,
    input  logic [32*FETCH_W-1:0]   in_inst,
    input  logic [FETCH_W-1:0]      in_addr_error,
    output logic                    in_ready,
    output logic [ISSUE_W-1:0]      out_valid,
    output logic [32*ISSUE_W-1:0]   out_pc,
    output logic [32*ISSUE_W-1:0]   out_inst,
    output logic [ISSUE_W-1:0]      out_addr_error,
    output logic [ISSUE_W-1:0]      out_is_branch,
    input  logic [$clog2(ISSUE_W):0] out_take,
    input  logic                    flush,
    input  logic                    redirect,
    output logic                    ds_pending,
    output logic                    dbg_state,
    output logic [CNT_W-1:0]        dbg_count
);

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             err_mem  [DEPTH];
    logic             br_mem   [DEPTH];

    iq_state_t        state;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [FETCH_W-1:0] lane_br;
    logic [FETCH_W-1:0] wr_mask;
    logic [CNT_W-1:0]   enq_cnt;
    logic [CNT_W-1:0]   take_cnt;
    logic [PTR_W-1:0]   head_take;
    logic [PTR_W-1:0]   last_idx;
    logic [CNT_W-1:0]   rem;
    logic               dp_take;

    for (genvar k = 0; k < FETCH_W; k++) begin : g_predecode
        branch_predecode u_predecode (
            .inst      (in_inst[32*k +: 32]),
            .is_branch (lane_br[k])
        );
    end

    // Readiness looks only at the current occupancy; a same-cycle dequeue
    // never opens room for a write.
    assign in_ready = (state == IQ_WAIT_DS) ||
                      ((CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_W));

    assign take_cnt  = CNT_W'(out_take);
    assign head_take = head + PTR_W'(out_take);
    assign last_idx  = head_take - PTR_W'(1);
    assign rem       = count - take_cnt;
    assign dp_take   = (take_cnt != '0) ? br_mem[last_idx] : ds_pending;

    always_comb begin
        wr_mask = '0;
        if (!flush) begin
            if (state == IQ_WAIT_DS) begin
                wr_mask[0] = in_valid[0];
            end else if (!redirect && in_ready) begin
                wr_mask = in_valid;
            end
        end
    end

    always_comb begin
        enq_cnt = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            enq_cnt = enq_cnt + CNT_W'(wr_mask[k]);
        end
    end

    // Entry storage carries no reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_W; k++) begin
            if (wr_mask[k]) begin
                pc_mem[tail + PTR_W'(k)]   <= in_pc[32*k +: 32];
                inst_mem[tail + PTR_W'(k)] <= in_inst[32*k +: 32];
                err_mem[tail + PTR_W'(k)]  <= in_addr_error[k];
                br_mem[tail + PTR_W'(k)]   <= lane_br[k];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IQ_RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            ds_pending <= 1'b0;
        end else if (flush) begin
            state      <= IQ_RUN;
            tail       <= head;
            count      <= '0;
            ds_pending <= 1'b0;
        end else if (state == IQ_WAIT_DS) begin
            if (in_valid[0]) begin
                tail  <= tail + PTR_W'(1);
                count <= count + CNT_W'(1);
                state <= IQ_RUN;
            end
        end else if (redirect) begin
            head       <= head_take;
            ds_pending <= dp_take;
            if (dp_take && (rem != '0)) begin
                tail  <= head_take + PTR_W'(1);
                count <= CNT_W'(1);
            end else begin
                tail  <= head_take;
                count <= '0;
                // The delay slot has not been fetched yet; capture it next.
                if (dp_take) begin
                    state <= IQ_WAIT_DS;
                end
            end
        end else begin
            head       <= head_take;
            tail       <= tail + enq_cnt[PTR_W-1:0];
            count      <= count - take_cnt + enq_cnt;
            ds_pending <= dp_take;
        end
    end

    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k]          = (count > CNT_W'(k));
            out_pc[32*k +: 32]    = pc_mem[head + PTR_W'(k)];
            out_inst[32*k +: 32]  = inst_mem[head + PTR_W'(k)];
            out_addr_error[k]     = err_mem[head + PTR_W'(k)];
            out_is_branch[k]      = br_mem[head + PTR_W'(k)];
        end
    end

    assign dbg_state = state;
    assign dbg_count = count;

    always @(posedge clk) begin
        if (resetn && !flush) begin
            assert (take_cnt <= count && take_cnt <= CNT_W'(ISSUE_W));
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised bench for inst_queue checked against a queue-level model of
// entries, delay-slot tracking and the wait-for-delay-slot condition.
module tb_inst_queue;

    localparam int DEPTH   = 8;
    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int TAKE_W  = $clog2(ISSUE_W) + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        err;
        logic        br;
    } entry_t;

    logic                   clk;
    logic                   resetn;
    logic [FETCH_W-1:0]     in_valid;
    logic [32*FETCH_W-1:0]  in_pc;
    logic [32*FETCH_W-1:0]  in_inst;
    logic [FETCH_W-1:0]     in_addr_error;
    logic                   in_ready;
    logic [ISSUE_W-1:0]     out_valid;
    logic [32*ISSUE_W-1:0]  out_pc;
    logic [32*ISSUE_W-1:0]  out_inst;
    logic [ISSUE_W-1:0]     out_addr_error;
    logic [ISSUE_W-1:0]     out_is_branch;
    logic [TAKE_W-1:0]      out_take;
    logic                   flush;
    logic                   redirect;
    logic                   ds_pending;
    logic                   dbg_state;
    logic [CNT_W-1:0]       dbg_count;

    inst_queue #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .in_valid       (in_valid),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_addr_error  (in_addr_error),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_addr_error (out_addr_error),
        .out_is_branch  (out_is_branch),
        .out_take       (out_take),
        .flush          (flush),
        .redirect       (redirect),
        .ds_pending     (ds_pending),
        .dbg_state      (dbg_state),
        .dbg_count      (dbg_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_vec;
    int     n_err;
    entry_t m_q[$];
    logic   m_ds;
    logic   m_wait;
    logic [31:0] next_pc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_branch(input logic [31:0] w);
        int op;
        int fn;
        int rt;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        rt = int'(w[20:16]);
        if (op >= 2 && op <= 7) return 1'b1;
        if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
        if (op == 1 && (rt == 0 || rt == 1 || rt == 16 || rt == 17)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 7))
            0: w[31:26] = 6'h04;
            1: w[31:26] = 6'h03;
            2: begin w[31:26] = 6'h00; w[5:0] = 6'($urandom_range(8, 9)); end
            3: w[31:26] = 6'h01;
            4: begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
            default: w[31:26] = 6'($urandom_range(8, 63));
        endcase
        return w;
    endfunction

    task automatic set_lane(input int k, input logic [31:0] pc, input logic [31:0] w, input logic err);
        in_pc[32*k +: 32]   = pc;
        in_inst[32*k +: 32] = w;
        in_addr_error[k]    = err;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        out_take = '0;
        flush    = 1'b0;
        redirect = 1'b0;
    endtask

    function automatic entry_t lane_entry(input int k);
        entry_t e;
        e.pc   = in_pc[32*k +: 32];
        e.inst = in_inst[32*k +: 32];
        e.err  = in_addr_error[k];
        e.br   = ref_branch(in_inst[32*k +: 32]);
        return e;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ds   = 1'b0;
        m_wait = 1'b0;
    endtask

    task automatic check_model(input string tag);
        int n_out;
        logic [ISSUE_W-1:0] ev;
        n_out = (m_q.size() < ISSUE_W) ? m_q.size() : ISSUE_W;
        ev = '0;
        for (int k = 0; k < n_out; k++) ev[k] = 1'b1;
        check_val({tag, ".count"}, 64'(dbg_count), 64'(m_q.size()));
        check_val({tag, ".valid"}, 64'(out_valid), 64'(ev));
        check_val({tag, ".ready"}, 64'(in_ready), 64'(m_wait || (DEPTH - m_q.size() >= FETCH_W)));
        check_val({tag, ".ds"}, 64'(ds_pending), 64'(m_ds));
        check_val({tag, ".state"}, 64'(dbg_state), 64'(m_wait));
        for (int k = 0; k < n_out; k++) begin
            check_val({tag, ".pc"}, 64'(out_pc[32*k +: 32]), 64'(m_q[k].pc));
            check_val({tag, ".inst"}, 64'(out_inst[32*k +: 32]), 64'(m_q[k].inst));
            check_val({tag, ".err"}, 64'(out_addr_error[k]), 64'(m_q[k].err));
            check_val({tag, ".br"}, 64'(out_is_branch[k]), 64'(m_q[k].br));
        end
    endtask

    // driver: apply one cycle of stimulus, advance the model, check after the edge
    task automatic cycle(input string tag, input logic [FETCH_W-1:0] v, input int take,
                         input logic fl, input logic rd);
        logic   ready;
        entry_t e;
        in_valid = v;
        out_take = TAKE_W'(take);
        flush    = fl;
        redirect = rd;
        ready = m_wait || (DEPTH - m_q.size() >= FETCH_W);
        if (fl) begin
            model_reset();
        end else if (m_wait) begin
            if (v[0]) begin
                m_q.push_back(lane_entry(0));
                m_wait = 1'b0;
            end
        end else begin
            for (int i = 0; i < take; i++) begin
                e = m_q.pop_front();
                m_ds = e.br;
            end
            if (rd) begin
                if (!m_ds) begin
                    m_q.delete();
                end else if (m_q.size() > 0) begin
                    e = m_q[0];
                    m_q.delete();
                    m_q.push_back(e);
                end else begin
                    m_wait = 1'b1;
                end
            end else if (ready) begin
                for (int k = 0; k < FETCH_W; k++) begin
                    if (v[k]) m_q.push_back(lane_entry(k));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        check_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        check_val({tag, ".valid"}, 64'(out_valid), 64'(0));
        check_val({tag, ".ready"}, 64'(in_ready), 64'(1));
        check_val({tag, ".ds"}, 64'(ds_pending), 64'(0));
        check_val({tag, ".state"}, 64'(dbg_state), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic plain_pair(input logic [31:0] pc);
        set_lane(0, pc, 32'h2401_0001, 1'b0);
        set_lane(1, pc + 32'd4, 32'h0022_1821, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        resetn = 1'b0;
        idle_inputs();
        in_pc = '0;
        in_inst = '0;
        in_addr_error = '0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        check_model("reset");

        // basic enqueue, next-cycle visibility
        plain_pair(32'h1000);
        cycle("enq", 2'b11, 0, 1'b0, 1'b0);
        check_val("enq.pc_pair", 64'(out_pc), 64'h0000_1004_0000_1000);

        // fill to full; extra write dropped; take opens room
        for (int i = 1; i < 4; i++) begin
            plain_pair(32'h1000 + 32'(8 * i));
            cycle("fill", 2'b11, 0, 1'b0, 1'b0);
        end
        check_val("full.ready", 64'(in_ready), 64'(0));
        plain_pair(32'h1100);
        cycle("drop", 2'b11, 0, 1'b0, 1'b0);
        check_val("drop.count", 64'(dbg_count), 64'(8));
        cycle("take2", 2'b00, 2, 1'b0, 1'b0);
        check_val("take2.count", 64'(dbg_count), 64'(6));
        for (int i = 0; i < 12; i++) begin
            plain_pair(32'h1200 + 32'(8 * i));
            cycle("wrap", 2'b11, 2, 1'b0, 1'b0);
        end
        cycle("flush0", 2'b00, 0, 1'b1, 1'b0);

        // beq consumed, redirect keeps delay slot only
        set_lane(0, 32'h2000, 32'h1022_0003, 1'b0);
        set_lane(1, 32'h2004, 32'h0022_1821, 1'b1);
        cycle("beq_enq", 2'b11, 0, 1'b0, 1'b0);
        set_lane(0, 32'h2008, 32'h2401_0002, 1'b0);
        cycle("beq_enq2", 2'b01, 0, 1'b0, 1'b0);
        cycle("beq_take", 2'b00, 1, 1'b0, 1'b0);
        check_val("beq_take.ds", 64'(ds_pending), 64'(1));
        cycle("beq_redir", 2'b00, 0, 1'b0, 1'b1);
        check_val("beq_redir.pc", 64'(out_pc[31:0]), 64'h2004);
        check_val("beq_redir.count", 64'(dbg_count), 64'(1));
        cycle("ds_take", 2'b00, 1, 1'b0, 1'b0);
        check_val("ds_take.ds", 64'(ds_pending), 64'(0));

        // jal as last entry, redirect -> wait for delay slot
        set_lane(0, 32'h3000, 32'h0C00_0400, 1'b0);
        cycle("jal_enq", 2'b01, 0, 1'b0, 1'b0);
        cycle("jal_redir", 2'b00, 1, 1'b0, 1'b1);
        check_val("jal_redir.state", 64'(dbg_state), 64'(1));
        cycle("wait_redir", 2'b00, 0, 1'b0, 1'b1);
        plain_pair(32'h3004);
        cycle("ds_fill", 2'b11, 0, 1'b0, 1'b0);
        check_val("ds_fill.pc", 64'(out_pc[31:0]), 64'h3004);
        check_val("ds_fill.state", 64'(dbg_state), 64'(0));

        // count 5 with ds pending, then flush + redirect together
        set_lane(0, 32'h300C, 32'h1400_0004, 1'b0);
        set_lane(1, 32'h3010, 32'h0022_1821, 1'b0);
        cycle("c5a", 2'b11, 0, 1'b0, 1'b0);
        plain_pair(32'h3014);
        cycle("c5b", 2'b11, 0, 1'b0, 1'b0);
        cycle("c5c", 2'b00, 2, 1'b0, 1'b0);
        plain_pair(32'h301C);
        cycle("c5d", 2'b11, 0, 1'b0, 1'b0);
        check_val("c5.count", 64'(dbg_count), 64'(5));
        cycle("fl_rd", 2'b11, 1, 1'b1, 1'b1);

        // asynchronous reset with 4 entries, then while waiting for a delay slot
        plain_pair(32'h4000);
        cycle("ar1a", 2'b11, 0, 1'b0, 1'b0);
        plain_pair(32'h4008);
        cycle("ar1b", 2'b11, 0, 1'b0, 1'b0);
        async_reset("arst_cnt");
        check_model("arst_cnt_post");
        set_lane(0, 32'h5000, 32'h0800_0100, 1'b0);
        cycle("ar2a", 2'b01, 0, 1'b0, 1'b0);
        cycle("ar2b", 2'b00, 1, 1'b0, 1'b1);
        async_reset("arst_wait");
        check_model("arst_wait_post");

        // randomised traffic
        next_pc = 32'h8000_0000;
        for (int i = 0; i < 800; i++) begin
            int n_in;
            int max_take;
            logic [FETCH_W-1:0] v;
            n_in = $urandom_range(0, FETCH_W);
            v = '0;
            for (int k = 0; k < FETCH_W; k++) begin
                if (k < n_in) v[k] = 1'b1;
                set_lane(k, next_pc + 32'(4 * k), rand_inst(), ($urandom_range(0, 15) == 0));
            end
            max_take = (m_q.size() < ISSUE_W) ? m_q.size() : ISSUE_W;
            cycle("rand", v, $urandom_range(0, max_take),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 11) == 0));
            next_pc = next_pc + 32'(4 * FETCH_W);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised instruction buffer between IF and ID.
- Accepts up to FETCH_W fetched instructions per cycle and presents up to ISSUE_W oldest entries to the decoder(s) in program order.
- Pre-decodes branch/jump class per entry.
- Handles MIPS delay-slot semantics on branch redirect: the delay slot survives, everything younger is dropped. Exception/eret flush clears all entries.

Parameters:
- DEPTH, 8: entries; power of two, >= 2*FETCH_W.
- FETCH_W, 2: enqueue lanes, 1..4.
- ISSUE_W, 2: dequeue lanes, 1..ISSUE_W <= DEPTH.
- PTR_W, $clog2(DEPTH): pointer width, derived.
- CNT_W, $clog2(DEPTH)+1: occupancy width, derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  FETCH_W  per-lane valid; must be contiguous from lane 0.
- in_pc  in  32*FETCH_W  lane k at bits [32k+31:32k].
- in_inst  in  32*FETCH_W  instruction words.
- in_addr_error  in  FETCH_W  fetch address error per lane.
- in_ready  out  1  free entries >= FETCH_W.
- out_valid  out  ISSUE_W  contiguous from lane 0; lane k valid iff count > k.
- out_pc  out  32*ISSUE_W  entry head+k.
- out_inst  out  32*ISSUE_W  entry head+k.
- out_addr_error  out  ISSUE_W  entry head+k.
- out_is_branch  out  ISSUE_W  entry head+k is J/JAL/JR/JALR/BEQ/BNE/BLEZ/BGTZ/REGIMM branch.
- out_take  in  $clog2(ISSUE_W)+1  entries consumed this cycle; must be <= popcount(out_valid).
- flush  in  1  exception/eret: clear everything.
- redirect  in  1  branch resolved taken: keep delay slot only.
- ds_pending  out  1  last consumed entry was a branch whose delay slot is not yet consumed.

Behaviour:
- Reset (async, resetn=0): head=0, tail=0, count=0, ds_pending=0, state=RUN. Result: out_valid=0, in_ready=1. Storage is not reset; out_* data are don't-care while invalid.
- Storage: DEPTH entries of {pc, inst, addr_error, is_branch}. is_branch is computed at enqueue by branch_predecode and stored.
- Enqueue: when in_ready and not (flush or redirect), write lane k at tail+k (mod DEPTH) for each set in_valid[k]. tail += popcount(in_valid). If in_ready=0, inputs are ignored; fetch must hold.
- Latency: entry written at edge N is visible on out_* from cycle N+1.
- Dequeue: head += out_take; count updates by +enq-take in the same cycle. Pointers wrap mod DEPTH.
- out_take > valid count is illegal; verification asserts it.
- ds_pending update, when out_take = n > 0: ds_pending <= is_branch of entry head+n-1. n=0 leaves it unchanged. A dequeued delay slot (non-branch) clears it.
- States: RUN, WAIT_DS.
- Priority, highest first: resetn > flush > redirect > enqueue/dequeue.
- flush (any state): count=0, tail=head, ds_pending=0, state=RUN. out_take and in_valid are ignored that cycle.
- redirect in RUN:
  - Compute ds_pending after applying this cycle's out_take (dp').
  - dp'=0: clear queue.
  - dp'=1 and remaining count>0: keep exactly the oldest remaining entry (count=1, tail=head'+1).
  - dp'=1 and remaining count=0: clear queue; state -> WAIT_DS.
  - Same-cycle enqueue is always discarded.
- WAIT_DS:
  - in_ready=1.
  - The first cycle with in_valid[0]=1 stores lane 0 only (the delay slot); other lanes are discarded. state -> RUN.
  - redirect in WAIT_DS is ignored. flush returns to RUN.
- Simultaneous enqueue+dequeue when full: in_ready reflects current count only, so no write occurs while free < FETCH_W, even if a dequeue happens that cycle.
- All outputs are combinational from registered state; no combinational path from in_* to out_*.

Decomposition:
- Shared header head.vh gains:
  - opcode constants SPEC, REGIMM, J, JAL, BEQ, BNE, BLEZ, BGTZ;
  - func constants JR, JALR;
  - state encodings IQ_RUN, IQ_WAIT_DS.
- One sub-module: branch_predecode. Combinational, 32-bit inst in, is_branch out, instantiated FETCH_W times at the enqueue side.

Test Plan:
- Reset then enqueue lanes {0x1000: addiu, 0x1004: addu} -> next cycle out_valid=2'b11, out_pc={0x1004,0x1000}, ds_pending=0.
- Fill queue (DEPTH=8, 4 cycles x 2) with out_take=0 -> in_ready=0 at count 8; a further in_valid is dropped. Take 2 -> count 6, in_ready=1. Pointer wrap is correct over 3 full cycles.
- Consume beq at 0x2000 alone (out_take=1); queue holds 0x2004, 0x2008; assert redirect -> next cycle count=1, out_pc[0]=0x2004. After it is taken, ds_pending=0.
- Consume a jal that is the last queued entry, then redirect -> WAIT_DS. Next in_valid=2'b11 {0x3004, 0x3008} -> only 0x3004 stored, state RUN.
- flush and redirect in the same cycle with count=5 -> count=0, ds_pending=0, state RUN.
- Async reset mid-operation (count=4, WAIT_DS) -> immediately out_valid=0, in_ready=1, ds_pending=0 without a clock edge.
